// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: multicycle controller states, ALU control codes and Funct command codes
package arm_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_MOV = 4'b1101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: Funct[4:0] to ALUControl/FlagW, flagging undefined and CMP commands
module alu_decoder
    import arm_ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [4:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic [1:0] o_flag_w,
    output logic       o_undef,
    output logic       o_cmp
);
    logic w_ext;
    logic w_arith;
    logic w_s;
    assign w_ext = EXT_OPS != 0;
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_undef = 1'b0;
        o_cmp = 1'b0;
        w_arith = 1'b0;
        case (i_funct[4:1])
            CMD_ADD: w_arith = 1'b1;
            CMD_SUB: begin o_alu_ctrl = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: o_alu_ctrl = ALU_AND;
            CMD_ORR: o_alu_ctrl = ALU_ORR;
            CMD_EOR: begin o_alu_ctrl = w_ext ? ALU_EOR : ALU_ADD; o_undef = !w_ext; end
            CMD_CMP: begin o_alu_ctrl = w_ext ? ALU_SUB : ALU_ADD; w_arith = w_ext; o_cmp = w_ext; o_undef = !w_ext; end
            CMD_MOV: begin o_alu_ctrl = w_ext ? ALU_MOV : ALU_ADD; o_undef = !w_ext; end
            default: o_undef = 1'b1;
        endcase
        w_s = i_funct[0] | o_cmp;
        o_flag_w = o_undef ? 2'b00 : {w_s, w_s & w_arith};
    end
endmodule

// File: rtl/multicycle_decode.sv
// multicycle_decode: Moore control FSM for a multicycle ARM-subset datapath
module multicycle_decode
    import arm_ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       PCS,
    output logic [1:0] FlagW,
    output logic [2:0] ALUControl,
    output logic       Undef
);
    state_t     r_state;
    state_t     w_st;
    state_t     w_next;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_flag_w;
    logic       w_alu_undef;
    logic       w_cmp;
    logic       w_exec;
    alu_decoder #(.EXT_OPS(EXT_OPS)) u_alu_decoder (
        .i_funct   (Funct[4:0]),
        .o_alu_ctrl(w_alu_ctrl),
        .o_flag_w  (w_flag_w),
        .o_undef   (w_alu_undef),
        .o_cmp     (w_cmp)
    );
    always_ff @(posedge clk) r_state <= reset ? FETCH : w_next;
    // Reset shows FETCH immediately so an aborted MEMWR/ALUWB never strobes a write
    assign w_st = reset ? FETCH : r_state;
    assign w_exec = (w_st == EXECR) || (w_st == EXECI);
    always_comb begin
        w_next = w_st;
        IRWrite = 1'b0;
        NextPC = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        ResultSrc = 2'b00;
        RegW = 1'b0;
        MemW = 1'b0;
        Branch = 1'b0;
        Undef = 1'b0;
        case (w_st)
            FETCH: begin
                w_next = MemReady ? DECODE : FETCH;
                IRWrite = MemReady & ~reset;
                NextPC = MemReady & ~reset;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                w_next = (Op == 2'b01) ? MEMADR : (Op == 2'b10) ? BRANCH : (Op == 2'b11) ? FETCH : Funct[5] ? EXECI : EXECR;
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ResultSrc = 2'b10;
                Undef = Op == 2'b11;
            end
            MEMADR: begin w_next = Funct[0] ? MEMRD : MEMWR; ALUSrcB = 2'b01; end
            MEMRD: begin w_next = MemReady ? MEMWB : MEMRD; AdrSrc = 1'b1; end
            MEMWB: begin w_next = FETCH; ResultSrc = 2'b01; RegW = 1'b1; end
            MEMWR: begin w_next = MemReady ? FETCH : MEMWR; AdrSrc = 1'b1; MemW = MemReady; end
            EXECR, EXECI: begin
                w_next = (w_cmp | w_alu_undef) ? FETCH : ALUWB;
                ALUSrcB = (w_st == EXECI) ? 2'b01 : 2'b00;
                Undef = w_alu_undef;
            end
            ALUWB: begin w_next = FETCH; RegW = 1'b1; end
            BRANCH: begin w_next = FETCH; ALUSrcB = 2'b01; ResultSrc = 2'b10; Branch = 1'b1; end
            default: w_next = FETCH;
        endcase
    end
    assign ALUControl = w_exec ? w_alu_ctrl : ALU_ADD;
    assign FlagW = w_exec ? w_flag_w : 2'b00;
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b10, Op == 2'b01};
    assign PCS = ((Rd == 4'hF) & RegW) | Branch;
endmodule

// File: tb/tb_multicycle_decode.sv
// tb_multicycle_decode: per-cycle output check of both EXT_OPS variants against an instruction-level model
module tb_multicycle_decode;
    typedef struct packed {
        logic       irw;
        logic       npc;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic       regw;
        logic       memw;
        logic       br;
        logic       pcs;
        logic [1:0] flagw;
        logic [2:0] aluc;
        logic       undef;
    } out_t;
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;
    logic clk = 1'b0;
    logic rst = 1'b1, rst0 = 1'b1, mr = 1'b1;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'b0;
    logic [3:0] rd = 4'b0;
    logic irw1, npc1, adr1, srca1, regw1, memw1, br1, pcs1, und1;
    logic [1:0] srcb1, res1, imm1, rs1, fw1;
    logic [2:0] alu1;
    logic irw0, npc0, adr0, srca0, regw0, memw0, br0, pcs0, und0;
    logic [1:0] srcb0, res0, imm0, rs0, fw0;
    logic [2:0] alu0;
    out_t o1, o0;
    int checks = 0, errors = 0;
    int q_ph[$];
    bit q_mr[$];
    always #5 clk = ~clk;
    multicycle_decode #(.EXT_OPS(1)) dut1 (
        .clk(clk), .reset(rst), .Op(op), .Funct(funct), .Rd(rd), .MemReady(mr),
        .IRWrite(irw1), .NextPC(npc1), .AdrSrc(adr1), .ALUSrcA(srca1), .ALUSrcB(srcb1),
        .ResultSrc(res1), .ImmSrc(imm1), .RegSrc(rs1), .RegW(regw1), .MemW(memw1),
        .Branch(br1), .PCS(pcs1), .FlagW(fw1), .ALUControl(alu1), .Undef(und1)
    );
    multicycle_decode #(.EXT_OPS(0)) dut0 (
        .clk(clk), .reset(rst0), .Op(op), .Funct(funct), .Rd(rd), .MemReady(mr),
        .IRWrite(irw0), .NextPC(npc0), .AdrSrc(adr0), .ALUSrcA(srca0), .ALUSrcB(srcb0),
        .ResultSrc(res0), .ImmSrc(imm0), .RegSrc(rs0), .RegW(regw0), .MemW(memw0),
        .Branch(br0), .PCS(pcs0), .FlagW(fw0), .ALUControl(alu0), .Undef(und0)
    );
    assign o1 = {irw1, npc1, adr1, srca1, srcb1, res1, imm1, rs1, regw1, memw1, br1, pcs1, fw1, alu1, und1};
    assign o0 = {irw0, npc0, adr0, srca0, srcb0, res0, imm0, rs0, regw0, memw0, br0, pcs0, fw0, alu0, und0};

    function automatic void ref_alu(input logic [5:0] f, input bit ext, output logic [2:0] a,
                                    output logic [1:0] fw, output bit und, output bit cmp);
        logic [3:0] c;
        bit arith;
        c = f[4:1];
        und = 0; cmp = 0; arith = 0; a = 3'd0;
        if (c == 4'b0100) arith = 1;
        else if (c == 4'b0010) begin a = 3'd1; arith = 1; end
        else if (c == 4'b0000) a = 3'd2;
        else if (c == 4'b1100) a = 3'd3;
        else if (ext && c == 4'b0001) a = 3'd4;
        else if (ext && c == 4'b1010) begin a = 3'd1; arith = 1; cmp = 1; end
        else if (ext && c == 4'b1101) a = 3'd5;
        else und = 1;
        fw[1] = f[0] | cmp;
        fw[0] = fw[1] & arith;
        if (und) fw = 2'b00;
    endfunction

    function automatic out_t exp_out(input int ph, input bit m, input logic [1:0] o, input logic [5:0] f,
                                     input logic [3:0] r, input bit ext);
        out_t e;
        bit u, c;
        e = '0;
        e.imm = o;
        e.regsrc = {o == 2'b10, o == 2'b01};
        case (ph)
            P_FETCH: begin e.irw = m; e.npc = m; e.srca = 1; e.srcb = 2; e.res = 2; end
            P_DECODE: begin e.srca = 1; e.srcb = 2; e.res = 2; e.undef = (o == 2'b11); end
            P_MEMADR: e.srcb = 1;
            P_MEMRD: e.adr = 1;
            P_MEMWB: begin e.res = 1; e.regw = 1; end
            P_MEMWR: begin e.adr = 1; e.memw = m; end
            P_EXECR, P_EXECI: begin
                e.srcb = (ph == P_EXECI) ? 2'd1 : 2'd0;
                ref_alu(f, ext, e.aluc, e.flagw, u, c);
                e.undef = u;
            end
            P_ALUWB: e.regw = 1;
            P_BRANCH: begin e.srcb = 1; e.res = 2; e.br = 1; end
            default: ;
        endcase
        e.pcs = (r == 4'hF && e.regw) || e.br;
        return e;
    endfunction

    function automatic void push(input int p, input bit m);
        q_ph.push_back(p);
        q_mr.push_back(m);
    endfunction

    // sf/sm: MemReady-low cycles in FETCH and in MEMRD/MEMWR; negative means random
    task automatic run_instr(input bit ext, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input int sf, input int sm, input string name);
        logic [2:0] a;
        logic [1:0] fw;
        bit u, c;
        int nf, nm;
        out_t e, g;
        nf = (sf < 0) ? $urandom_range(0, 2) : sf;
        nm = (sm < 0) ? $urandom_range(0, 2) : sm;
        q_ph.delete();
        q_mr.delete();
        repeat (nf) push(P_FETCH, 0);
        push(P_FETCH, 1);
        push(P_DECODE, 1'($urandom));
        if (o == 2'b01) begin
            push(P_MEMADR, 1'($urandom));
            if (f[0]) begin
                repeat (nm) push(P_MEMRD, 0);
                push(P_MEMRD, 1);
                push(P_MEMWB, 1'($urandom));
            end else begin
                repeat (nm) push(P_MEMWR, 0);
                push(P_MEMWR, 1);
            end
        end else if (o == 2'b00) begin
            push(f[5] ? P_EXECI : P_EXECR, 1'($urandom));
            ref_alu(f, ext, a, fw, u, c);
            if (!u && !c) push(P_ALUWB, 1'($urandom));
        end else if (o == 2'b10) push(P_BRANCH, 1'($urandom));
        op = o; funct = f; rd = r;
        for (int i = 0; i < q_ph.size(); i++) begin
            mr = q_mr[i];
            e = exp_out(q_ph[i], q_mr[i], o, f, r, ext);
            @(negedge clk);
            g = ext ? o1 : o0;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cycle %0d phase %0d op=%b funct=%b: got %h expected %h", name, i, q_ph[i], o, f, g, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        out_t e;
        mr = 1; op = 2'b01; funct = 6'b0;
        e = exp_out(P_FETCH, 1, op, funct, rd, 1);
        e.irw = 0; e.npc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (o1 !== e) begin errors++; $display("FAIL reset_hold %0d: got %h expected %h", i, o1, e); end
            @(posedge clk); #1;
        end
        rst = 0;
    endtask

    task automatic test_directed;
        run_instr(1, 2'b00, 6'b101001, 4'd3, 0, 0, "adds_imm");
        run_instr(1, 2'b01, 6'b011001, 4'd2, 0, 2, "ldr_stall");
        run_instr(1, 2'b01, 6'b011000, 4'd2, 1, 1, "str_stall");
        run_instr(1, 2'b00, 6'b010101, 4'd0, 0, 0, "cmp_ext1");
        run_instr(1, 2'b00, 6'b011000, 4'hF, 0, 0, "orr_pc");
        run_instr(1, 2'b10, 6'b000000, 4'd0, 0, 0, "branch");
        run_instr(1, 2'b11, 6'b000000, 4'd0, 0, 0, "op11");
        run_instr(1, 2'b00, 6'b011111, 4'd1, 0, 0, "undef_cmd");
    endtask

    task automatic test_reset_memwr;
        out_t e;
        op = 2'b01; funct = 6'b000000; rd = 4'hF; mr = 1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        e = exp_out(P_FETCH, 1, op, funct, rd, 1);
        e.irw = 0; e.npc = 0;
        @(negedge clk);
        checks++;
        if (o1 !== e) begin errors++; $display("FAIL reset_in_memwr: got %h expected %h", o1, e); end
        @(posedge clk); #1;
        rst = 0; mr = 0;
        e = exp_out(P_FETCH, 0, op, funct, rd, 1);
        @(negedge clk);
        checks++;
        if (o1 !== e) begin errors++; $display("FAIL fetch_after_reset: got %h expected %h", o1, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++)
            run_instr(1, 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), -1, -1, "random_ext1");
    endtask

    task automatic test_ext0;
        rst = 1; rst0 = 0;
        run_instr(0, 2'b00, 6'b010101, 4'd0, 0, 0, "cmp_ext0");
        run_instr(0, 2'b00, 6'b111011, 4'hF, 0, 0, "mov_ext0");
        for (int i = 0; i < 20; i++)
            run_instr(0, 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom), -1, -1, "random_ext0");
        rst0 = 1; rst = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset;
        test_directed;
        test_reset_memwr;
        test_random;
        test_ext0;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
